mem_port_arbiter: RTL

- Shares one synchronous memory port between the core's instruction-fetch requester (read-only) and data requester (read/write, byte enables).
- Sits between the Riscv151 fetch/memory stages and the unified memory/cache backend.
- Single-outstanding-transaction FSM.
- Data side has fixed priority, with a starvation bound that guarantees fetch progress.

---
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between an instruction-fetch
// requester (read-only) and a data requester (read/write with byte enables).
// One transaction in flight at a time. Data side wins ties unless it has
// already won MAX_D_STREAK times in a row while fetch was waiting.
// Optional macro MEM_PORT_ARBITER_PERF_EN adds three 32-bit perf counters
// (I grants, D grants, IDLE cycles with both requesting).
module mem_port_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
`ifdef MEM_PORT_ARBITER_PERF_EN
  output logic [31:0] perf_i_grants,
  output logic [31:0] perf_d_grants,
  output logic [31:0] perf_conflicts,
`endif
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] MAX_S = 4'(MAX_D_STREAK);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      state_q;
  logic [3:0]  streak_q, streak_d;
  logic        owner_d_q;   // 1: data side owns the transaction in flight
  logic [31:0] mem_addr_q, mem_wdata_q, i_rdata_q, d_rdata_q;
  logic [3:0]  mem_we_q;
  logic        i_rvalid_q, d_rvalid_q;
  logic        i_win, d_win;

  // Same-cycle arbitration; grants are suppressed while reset is held so
  // every output reads 0 during reset.
  always_comb begin
    i_win = 1'b0;
    d_win = 1'b0;
    if (state_q == IDLE && !reset) begin
      if (d_req && !(i_req && streak_q == MAX_S)) d_win = 1'b1;
      else if (i_req)                            i_win = 1'b1;
    end
  end

  // Streak counter next value: counts D wins that kept fetch waiting.
  always_comb begin
    streak_d = streak_q;
    if (d_win) begin
      if (!i_req)                streak_d = 4'd0;
      else if (streak_q < MAX_S) streak_d = streak_q + 4'd1;
      else                       streak_d = MAX_S;
    end else if (i_win) begin
      streak_d = 4'd0;
    end
  end

  // Transaction FSM: latch winner, drive memory, route read data back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      streak_q    <= 4'd0;
      owner_d_q   <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_we_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
      i_rdata_q   <= 32'd0;
      d_rdata_q   <= 32'd0;
      i_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
    end else begin
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      streak_q   <= streak_d;
      case (state_q)
        IDLE: begin
          if (d_win) begin
            mem_addr_q  <= d_addr;
            mem_we_q    <= d_we;
            mem_wdata_q <= d_wdata;
            owner_d_q   <= 1'b1;
            state_q     <= REQ;
          end else if (i_win) begin
            mem_addr_q  <= i_addr;
            mem_we_q    <= 4'd0;
            mem_wdata_q <= 32'd0;
            owner_d_q   <= 1'b0;
            state_q     <= REQ;
          end
        end
        REQ: begin
          // Writes finish on acceptance; reads wait for data.
          if (mem_ready) state_q <= (|mem_we_q) ? IDLE : RESP;
        end
        RESP: begin
          if (mem_rvalid) begin
            state_q <= IDLE;
            if (owner_d_q) begin
              d_rdata_q  <= mem_rdata;
              d_rvalid_q <= 1'b1;
            end else begin
              i_rdata_q  <= mem_rdata;
              i_rvalid_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MEM_PORT_ARBITER_PERF_EN
  logic [31:0] perf_i_q, perf_d_q, perf_c_q;

  // Free-running event counters, wrapping modulo 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_i_q <= 32'd0;
      perf_d_q <= 32'd0;
      perf_c_q <= 32'd0;
    end else begin
      if (i_win) perf_i_q <= perf_i_q + 32'd1;
      if (d_win) perf_d_q <= perf_d_q + 32'd1;
      if (state_q == IDLE && i_req && d_req) perf_c_q <= perf_c_q + 32'd1;
    end
  end

  assign perf_i_grants  = perf_i_q;
  assign perf_d_grants  = perf_d_q;
  assign perf_conflicts = perf_c_q;
`endif

  assign i_gnt     = i_win;
  assign d_gnt     = d_win;
  assign mem_req   = (state_q == REQ);
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rvalid  = i_rvalid_q;
  assign i_rdata   = i_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;

endmodule
